// File: rtl/spi_master_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_master_pkg
// Description : Shared types and constants for the SPI master: controller
//               state encoding, default timing parameters and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    localparam int unsigned c_HALF_PERIOD_DEFAULT = 3;
    localparam int unsigned c_CS_GAP_DEFAULT      = 50;

    // Timer must hold the largest load value (CS_GAP-1 up to 1022).
    localparam int unsigned c_CNT_W     = 10;
    localparam int unsigned c_BIT_CNT_W = 3;
    localparam int unsigned c_DATA_W    = 8;

endpackage
`default_nettype wire

// File: rtl/spi_half_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_half_timer
// Description : Loadable down-counter. Loading value N makes the owning state
//               last N+1 cycles; expired_o is high while the count is zero.
// Ports       : clk_i      - system clock
//               rst_n_i    - synchronous active-low reset (count -> 0)
//               load_i     - load load_val_i this cycle
//               load_val_i - value to load
//               count_o    - current count
//               expired_o  - count has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module spi_half_timer
    import spi_master_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               load_i,
    input  logic [c_CNT_W-1:0] load_val_i,
    output logic [c_CNT_W-1:0] count_o,
    output logic               expired_o
);

    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Mode-0 SPI master, one byte per frame, MSB first. Each frame
//               is SETUP, 8 x HIGH with 7 x LOW between, then HOLD, all one
//               SCLK half-period long; frames are separated by a CS-high gap.
// Config      : SPI_MASTER_BURST_EN - when defined, a byte offered in the
//               last HOLD cycle is accepted and sent without raising CS.
// Ports       : clk_i, rst_n_i         - clock, synchronous active-low reset
//               tx_data_i/tx_valid_i   - byte to send / request
//               tx_ready_o             - request accepted this cycle if valid
//               rx_data_o/rx_valid_o   - received byte / one-cycle strobe
//               busy_o                 - controller not idle
//               sclk_o, cs_o, mosi_o   - SPI outputs (registered)
//               miso_i                 - SPI input, sampled on SCLK high
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = c_HALF_PERIOD_DEFAULT,
    parameter int unsigned CS_GAP      = c_CS_GAP_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [c_DATA_W-1:0] tx_data_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    output logic [c_DATA_W-1:0] rx_data_o,
    output logic                rx_valid_o,
    output logic                busy_o,
    output logic                sclk_o,
    output logic                cs_o,
    output logic                mosi_o,
    input  logic                miso_i
);

    localparam logic [c_CNT_W-1:0]     c_HALF_LOAD = c_CNT_W'(HALF_PERIOD - 1);
    localparam logic [c_CNT_W-1:0]     c_GAP_LOAD  = c_CNT_W'(CS_GAP - 1);
    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT  = c_BIT_CNT_W'(c_DATA_W - 1);

`ifdef SPI_MASTER_BURST_EN
    localparam logic c_BURST = 1'b1;
`else
    localparam logic c_BURST = 1'b0;
`endif

    state_t                 state_q, state_d;
    logic [c_DATA_W-1:0]    tx_shift_q, tx_shift_d;
    logic [c_DATA_W-1:0]    rx_shift_q, rx_shift_d;
    logic [c_DATA_W-1:0]    rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [c_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                   cs_q, cs_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;

    logic                   w_tmr_load;
    logic [c_CNT_W-1:0]     w_tmr_val;
    logic [c_CNT_W-1:0]     w_tmr_count;
    logic                   w_expired;
    logic                   w_tx_ready;
    logic                   w_accept;
    logic                   w_in_frame;
    logic                   w_drive_data;

    spi_half_timer u_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .count_o    (w_tmr_count),
        .expired_o  (w_expired)
    );

    // Ready is withheld during reset so a request overlapping reset is never
    // advertised as accepted.
    assign w_tx_ready = rst_n_i &&
                        ((state_q == ST_IDLE) ||
                         (c_BURST && (state_q == ST_HOLD) && w_expired));
    assign w_accept   = w_tx_ready && tx_valid_i;

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        w_tmr_load = 1'b0;
        w_tmr_val  = c_HALF_LOAD;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    tx_shift_d = tx_data_i;
                    bit_cnt_d  = '0;
                    w_tmr_load = 1'b1;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_expired) begin
                    w_tmr_load = 1'b1;
                    state_d    = ST_HIGH;
                end
            end
            ST_HIGH: begin
                // The timer still holds its load value only in the first
                // HIGH cycle, which is where miso is captured.
                if (w_tmr_count == c_HALF_LOAD) begin
                    rx_shift_d = {rx_shift_q[c_DATA_W-2:0], miso_i};
                end
                if (w_expired) begin
                    w_tmr_load = 1'b1;
                    if (bit_cnt_q == c_LAST_BIT) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_cnt_d  = bit_cnt_q + c_BIT_CNT_W'(1);
                        tx_shift_d = {tx_shift_q[c_DATA_W-2:0], 1'b0};
                        state_d    = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (w_expired) begin
                    w_tmr_load = 1'b1;
                    state_d    = ST_HIGH;
                end
            end
            ST_HOLD: begin
                if (w_expired) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    w_tmr_load = 1'b1;
                    if (w_accept) begin
                        tx_shift_d = tx_data_i;
                        bit_cnt_d  = '0;
                        state_d    = ST_SETUP;
                    end else begin
                        w_tmr_val = c_GAP_LOAD;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (w_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pin values are derived from the next state so they change on the
        // same edge as the state they belong to.
        w_in_frame   = (state_d == ST_SETUP) || (state_d == ST_HIGH) ||
                       (state_d == ST_LOW)   || (state_d == ST_HOLD);
        w_drive_data = (state_d == ST_SETUP) || (state_d == ST_HIGH) ||
                       (state_d == ST_LOW);
        cs_d         = !w_in_frame;
        sclk_d       = (state_d == ST_HIGH);
        mosi_d       = w_drive_data ? tx_shift_d[c_DATA_W-1] : 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            bit_cnt_q  <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            bit_cnt_q  <= bit_cnt_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    assign tx_ready_o = w_tx_ready;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign sclk_o     = sclk_q;
    assign cs_o       = cs_q;
    assign mosi_o     = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Testbench for spi_master. Unit 0 uses HALF_PERIOD=3/CS_GAP=50,
//               unit 1 uses HALF_PERIOD=1/CS_GAP=4. A pin-level monitor turns
//               each frame into bytes and durations that are compared with
//               values computed from the protocol rules.
// Config      : SPI_MASTER_BURST_EN selects the burst expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data [2];
    logic [1:0] tx_valid;
    logic [1:0] tx_ready, rx_valid, busy, sclk, cs, mosi, miso;
    logic [7:0] rx_data [2];
    logic [1:0] loop_en, drv;
    logic [7:0] pat [2];

    int checks   = 0;
    int failures = 0;

    // Monitor state, written only by the monitor process.
    int         run [2], rises [2], toggles [2], idx [2], hi_run [2];
    int         last_low [2], last_toggles [2], last_high [2];
    int         cs_rises [2], rxv_cnt [2], byte_rises [2];
    logic [7:0] bits [2], byte_bits [2], rx_last [2], rx_prev [2];
    logic       cs_prev [2], sclk_prev [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_unit
        spi_master #(
            .HALF_PERIOD ((g == 0) ? 3 : 1),
            .CS_GAP      ((g == 0) ? 50 : 4)
        ) u_dut (
            .clk_i      (clk),
            .rst_n_i    (rst_n),
            .tx_data_i  (tx_data[g]),
            .tx_valid_i (tx_valid[g]),
            .tx_ready_o (tx_ready[g]),
            .rx_data_o  (rx_data[g]),
            .rx_valid_o (rx_valid[g]),
            .busy_o     (busy[g]),
            .sclk_o     (sclk[g]),
            .cs_o       (cs[g]),
            .mosi_o     (mosi[g]),
            .miso_i     (miso[g])
        );
        assign miso[g] = loop_en[g] ? mosi[g] : drv[g];
    end

    function automatic int hp_of(input int u);
        return (u == 0) ? 3 : 1;
    endfunction

    function automatic int gap_of(input int u);
        return (u == 0) ? 50 : 4;
    endfunction

    // Pin-level monitor and mode-0 slave model: the slave shifts its next
    // pattern bit out on each SCLK falling edge.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!cs[u]) begin
                if (cs_prev[u]) begin
                    last_high[u] = hi_run[u];
                    run[u] = 0; rises[u] = 0; toggles[u] = 0; idx[u] = 0; bits[u] = '0;
                end
                run[u]++;
                if (sclk[u] != sclk_prev[u]) toggles[u]++;
                if (sclk[u] && !sclk_prev[u]) begin
                    rises[u]++;
                    bits[u] = {bits[u][6:0], mosi[u]};
                end
                if (!sclk[u] && sclk_prev[u]) idx[u]++;
            end else begin
                if (!cs_prev[u]) begin
                    last_low[u] = run[u]; last_toggles[u] = toggles[u];
                    hi_run[u] = 0; cs_rises[u]++;
                end
                hi_run[u]++;
            end
            if (rx_valid[u]) begin
                rxv_cnt[u]++;
                rx_prev[u] = rx_last[u]; rx_last[u] = rx_data[u];
                byte_bits[u] = bits[u]; byte_rises[u] = rises[u];
                bits[u] = '0; rises[u] = 0; idx[u] = 0;
            end
            drv[u] = (idx[u] < 8) ? pat[u][7 - idx[u]] : 1'b0;
            cs_prev[u] = cs[u]; sclk_prev[u] = sclk[u];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer one byte and wait (bounded) until it is taken.
    task automatic send(input int u, input logic [7:0] b, output bit ok);
        int n;
        n = 0;
        tx_data[u] = b; tx_valid[u] = 1'b1;
        while (!tx_ready[u] && n < 3000) begin tick(); n++; end
        ok = tx_ready[u];
        tick();
        tx_valid[u] = 1'b0;
        tx_data[u]  = 8'($urandom);
    endtask

    task automatic run_frame(input int u, input logic [7:0] b, input logic lp,
                             input logic [7:0] p, output bit ok);
        bit s_ok;
        int n;
        loop_en[u] = lp; pat[u] = p;
        send(u, b, s_ok);
        n = 0;
        while (busy[u] && n < 5000) begin tick(); n++; end
        ok = s_ok && !busy[u];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tx_valid = 2'b11; tx_data[0] = 8'hA5; tx_data[1] = 8'h5A;
        repeat (3) tick();
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({cs[u], sclk[u], mosi[u], rx_valid[u], busy[u], rx_data[u]} !== {5'b10000, 8'h00}) begin
                failures++;
                $display("FAIL reset_state u%0d: got cs/sclk/mosi/rxv/busy/rx=%b%b%b%b%b/%h required 10000/00",
                         u, cs[u], sclk[u], mosi[u], rx_valid[u], busy[u], rx_data[u]);
            end
        end
        rst_n = 1'b1; tx_valid = 2'b00;
        tick();
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({busy[u], tx_ready[u], cs[u]} !== 3'b011) begin
                failures++;
                $display("FAIL reset_release u%0d: got busy/ready/cs=%b%b%b required 011", u, busy[u], tx_ready[u], cs[u]);
            end
        end
    endtask

    task automatic test_loopback();
        bit ok;
        int v0;
        v0 = rxv_cnt[0];
        run_frame(0, 8'hAA, 1'b1, 8'h00, ok);
        checks++; if (!ok) begin failures++; $display("FAIL loop_done: got timeout required idle"); end
        checks++; if (byte_bits[0] !== 8'hAA) begin failures++; $display("FAIL loop_mosi: got %h required aa", byte_bits[0]); end
        checks++; if (rx_last[0] !== 8'hAA) begin failures++; $display("FAIL loop_rx: got %h required aa", rx_last[0]); end
        checks++; if (rxv_cnt[0] - v0 != 1) begin failures++; $display("FAIL loop_rxv: got %0d required 1", rxv_cnt[0] - v0); end
        checks++; if (last_low[0] != 17 * hp_of(0)) begin failures++; $display("FAIL loop_cs_low: got %0d required %0d", last_low[0], 17 * hp_of(0)); end
        checks++; if (byte_rises[0] != 8) begin failures++; $display("FAIL loop_rises: got %0d required 8", byte_rises[0]); end
    endtask

    task automatic test_miso_tied();
        bit ok;
        run_frame(0, 8'h33, 1'b0, 8'hFF, ok);
        checks++; if (!ok || rx_last[0] !== 8'hFF) begin failures++; $display("FAIL miso_one: got %h ok=%0d required ff", rx_last[0], ok); end
        checks++; if (byte_bits[0] !== 8'h33) begin failures++; $display("FAIL miso_one_mosi: got %h required 33", byte_bits[0]); end
        run_frame(0, 8'hFF, 1'b0, 8'h00, ok);
        checks++; if (!ok || rx_last[0] !== 8'h00) begin failures++; $display("FAIL miso_zero: got %h ok=%0d required 00", rx_last[0], ok); end
        checks++; if (byte_bits[0] !== 8'hFF) begin failures++; $display("FAIL miso_zero_mosi: got %h required ff", byte_bits[0]); end
    endtask

    task automatic test_hp1();
        bit ok;
        run_frame(1, 8'h5A, 1'b1, 8'h00, ok);
        checks++; if (!ok || rx_last[1] !== 8'h5A) begin failures++; $display("FAIL hp1_rx: got %h ok=%0d required 5a", rx_last[1], ok); end
        checks++; if (last_low[1] != 17) begin failures++; $display("FAIL hp1_cs_low: got %0d required 17", last_low[1]); end
        checks++; if (last_toggles[1] != 16) begin failures++; $display("FAIL hp1_toggles: got %0d required 16", last_toggles[1]); end
        checks++; if (byte_bits[1] !== 8'h5A) begin failures++; $display("FAIL hp1_mosi: got %h required 5a", byte_bits[1]); end
    endtask

    task automatic test_random();
        bit         ok;
        int         u;
        logic [7:0] b, p, exp_rx;
        logic       lp;
        for (int i = 0; i < 8; i++) begin
            u  = i % 2;
            b  = 8'($urandom);
            p  = 8'($urandom);
            lp = 1'($urandom_range(0, 1));
            exp_rx = lp ? b : p;
            run_frame(u, b, lp, p, ok);
            checks++;
            if (!ok || rx_last[u] !== exp_rx || byte_bits[u] !== b) begin
                failures++;
                $display("FAIL random_%0d u%0d: got rx=%h mosi=%h ok=%0d required rx=%h mosi=%h", i, u, rx_last[u], byte_bits[u], ok, exp_rx, b);
            end
            checks++;
            if (last_low[u] != 17 * hp_of(u) || last_toggles[u] != 16) begin
                failures++;
                $display("FAIL random_timing_%0d u%0d: got low=%0d toggles=%0d required %0d/16", i, u, last_low[u], last_toggles[u], 17 * hp_of(u));
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0, v0, n;
        loop_en[0] = 1'b1;
        c0 = cs_rises[0]; v0 = rxv_cnt[0];
        tx_data[0] = 8'hFF; tx_valid[0] = 1'b1;
        n = 0; while (!tx_ready[0] && n < 3000) begin tick(); n++; end
        tick();
        tx_data[0] = 8'h00;
        n = 0; while (!tx_ready[0] && n < 3000) begin tick(); n++; end
        checks++; if (!tx_ready[0]) begin failures++; $display("FAIL b2b_second_accept: got timeout required ready"); end
        tick();
        tx_valid[0] = 1'b0;
        n = 0; while (busy[0] && n < 5000) begin tick(); n++; end
        checks++;
        if (rxv_cnt[0] - v0 != 2 || rx_prev[0] !== 8'hFF || rx_last[0] !== 8'h00) begin
            failures++;
            $display("FAIL b2b_rx: got pulses=%0d bytes=%h,%h required 2 ff,00", rxv_cnt[0] - v0, rx_prev[0], rx_last[0]);
        end
`ifdef SPI_MASTER_BURST_EN
        checks++; if (cs_rises[0] - c0 != 1) begin failures++; $display("FAIL b2b_cs_rises: got %0d required 1", cs_rises[0] - c0); end
        checks++; if (last_low[0] != 34 * hp_of(0)) begin failures++; $display("FAIL b2b_cs_low: got %0d required %0d", last_low[0], 34 * hp_of(0)); end
`else
        checks++; if (cs_rises[0] - c0 != 2) begin failures++; $display("FAIL b2b_cs_rises: got %0d required 2", cs_rises[0] - c0); end
        checks++; if (last_high[0] != gap_of(0) + 1) begin failures++; $display("FAIL b2b_gap: got %0d required %0d", last_high[0], gap_of(0) + 1); end
`endif
    endtask

    task automatic test_reset_midframe();
        bit         ok;
        int         v0, n;
        logic [7:0] b;
        loop_en[0] = 1'b1;
        v0 = rxv_cnt[0];
        tx_data[0] = 8'hC3; tx_valid[0] = 1'b1;
        n = 0; while (!tx_ready[0] && n < 3000) begin tick(); n++; end
        tick();
        tx_valid[0] = 1'b0;
        n = 0; while (rises[0] < 4 && n < 3000) begin tick(); n++; end
        checks++; if (rises[0] != 4) begin failures++; $display("FAIL midreset_rise4: got %0d required 4", rises[0]); end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({cs[0], sclk[0], mosi[0], busy[0], rx_valid[0]} !== 5'b10000) begin
            failures++;
            $display("FAIL midreset_state: got cs/sclk/mosi/busy/rxv=%b%b%b%b%b required 10000", cs[0], sclk[0], mosi[0], busy[0], rx_valid[0]);
        end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (tx_ready[0] !== 1'b1) begin failures++; $display("FAIL midreset_ready: got %b required 1", tx_ready[0]); end
        checks++; if (rxv_cnt[0] != v0) begin failures++; $display("FAIL midreset_rxv: got %0d pulses required 0", rxv_cnt[0] - v0); end
        b = 8'($urandom);
        run_frame(0, b, 1'b1, 8'h00, ok);
        checks++; if (!ok || rx_last[0] !== b) begin failures++; $display("FAIL midreset_recover: got %h ok=%0d required %h", rx_last[0], ok, b); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            run[u] = 0; rises[u] = 0; toggles[u] = 0; idx[u] = 8; hi_run[u] = 0;
            last_low[u] = 0; last_toggles[u] = 0; last_high[u] = 0;
            cs_rises[u] = 0; rxv_cnt[u] = 0; byte_rises[u] = 0;
            bits[u] = '0; byte_bits[u] = '0; rx_last[u] = '0; rx_prev[u] = '0;
            cs_prev[u] = 1'b1; sclk_prev[u] = 1'b0;
            tx_data[u] = '0; pat[u] = '0;
        end
        tx_valid = '0; loop_en = '0; drv = '0; rst_n = 1'b0;

        test_reset();
        test_loopback();
        test_miso_tied();
        test_hp1();
        test_random();
        test_back_to_back();
        test_reset_midframe();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter HALF_PERIOD, default 3, clk cycles per SCLK half-period; legal range 1..255.
REQ-002 Parameter CS_GAP, default 50, minimum clk cycles CS stays high between frames; legal range 1..1023.
REQ-003 clk  input  1  system clock; every register SHALL update on its rising edge only.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 tx_data  input  8  byte to transmit, MSB first.
REQ-006 tx_valid  input  1  request to send tx_data.
REQ-007 tx_ready  output  1  block can accept a byte this cycle.
REQ-008 rx_data  output  8  byte sampled from miso during the last frame.
REQ-009 rx_valid  output  1  one-cycle pulse; rx_data is valid.
REQ-010 busy  output  1  high whenever not in IDLE.
REQ-011 sclk  output  1  SPI clock, idles low (mode 0).
REQ-012 cs  output  1  chip select, active-low, idles high.
REQ-013 mosi  output  1  serial data out.
REQ-014 miso  input  1  serial data in; synchronous to sclk, no internal synchroniser.

Function
REQ-015 States SHALL be IDLE, SETUP, HIGH, LOW, HOLD, GAP.
REQ-016 tx_ready SHALL be 1 only in IDLE (and in HOLD per REQ-028); transfer accepted when tx_valid && tx_ready.
REQ-017 On accept from IDLE: latch tx_data into shift register, next cycle cs=0, sclk=0, mosi=bit7, enter SETUP.
REQ-018 SETUP, HIGH, LOW, HOLD each SHALL last exactly HALF_PERIOD clk cycles, timed by one down-counter.
REQ-019 SETUP->HIGH: sclk=1; miso SHALL be sampled into the rx shift register in the first cycle of HIGH.
REQ-020 HIGH->LOW: sclk=0, mosi presents the next bit; after the 8th HIGH go to HOLD instead of LOW.
REQ-021 LOW->HIGH as REQ-019; bit counter 0..7 SHALL not wrap within a frame.
REQ-022 HOLD: sclk=0, mosi=0; on expiry cs=1, rx_valid pulses one cycle with rx_data updated, enter GAP.
REQ-023 cs SHALL be low for exactly 17*HALF_PERIOD clk cycles per frame; exactly 8 sclk rising edges per frame.
REQ-024 GAP: cs=1 for CS_GAP cycles, then IDLE; tx_valid during GAP SHALL be ignored (tx_ready=0).
REQ-025 tx_data changes after accept SHALL not affect the frame in flight.

Reset
REQ-026 rst_n=0 at a clk edge SHALL, from the next cycle, force IDLE, cs=1, sclk=0, mosi=0, tx_ready=1 (after release), rx_valid=0, rx_data=8'h00, busy=0, counters cleared; mid-frame reset aborts without rx_valid.
REQ-027 tx_valid asserted in the cycle rst_n=0 SHALL be dropped.

Configuration
REQ-028 Macro SPI_MASTER_BURST_EN defined: in the final HOLD cycle tx_ready=1; if accepted, rx_valid still pulses, cs stays low, GAP skipped, next byte proceeds via SETUP. Undefined: tx_ready=0 in HOLD, every frame ends with GAP.

Structure
REQ-029 Package spi_master_pkg SHALL hold the state enum, HALF_PERIOD/CS_GAP defaults and counter width constants.
REQ-030 One sub-module spi_half_timer (loadable down-counter, expiry strobe) SHALL serve both the half-period and GAP timing.

Verification
REQ-031 miso looped to mosi, send 8'hAA -> mosi 1,0,1,0,1,0,1,0 at sclk rises, rx_data=8'hAA, rx_valid one pulse, cs low 51 cycles.
REQ-032 miso tied 1, send 8'h33 -> rx_data=8'hFF; miso tied 0, send 8'hFF -> rx_data=8'h00.
REQ-033 8'hFF then 8'h00 with tx_valid held -> second accepted only after 50 GAP cycles (burst off); cs never high between them (burst on).
REQ-034 rst_n low at 4th sclk rise -> next cycle cs=1, sclk=0, no rx_valid, tx_ready=1 after release.
REQ-035 HALF_PERIOD=1 -> cs low 17 cycles, sclk toggles every cycle, rx_data correct for 8'h5A loopback.
